// File: rtl/pll_reconfig_sequencer_if.sv
// Avalon-MM management port between the reconfig sequencer and the PLL
// reconfiguration block.
interface pll_reconfig_sequencer_if;
    logic [5:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        waitrequest;

    modport master (
        output address, read, write, writedata,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, read, write, writedata,
        output readdata, waitrequest
    );
endinterface

// File: rtl/pll_reconfig_sequencer.sv
// Programs MODE, M, N, C counters, BW and CP through the PLL reconfig port,
// triggers START and polls status with a bounded retry loop.
module pll_reconfig_sequencer #(
    parameter int NUM_C      = 1,
    parameter int GAP        = 2,
    parameter int POLL_LIMIT = 64,
    parameter int MAX_RETRY  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [17:0]          cfg_m,
    input  logic [17:0]          cfg_n,
    input  logic [18*NUM_C-1:0]  cfg_c,
    input  logic [3:0]           cfg_bw,
    input  logic [2:0]           cfg_cp,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    pll_reconfig_sequencer_if.master mgmt
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WR   = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;
    localparam logic [1:0] S_POLL = 2'd3;

    localparam logic [3:0] W_C0      = 4'd3;
    localparam logic [3:0] W_BW      = 4'(3 + NUM_C);
    localparam logic [3:0] W_CP      = 4'(4 + NUM_C);
    localparam logic [3:0] W_ST      = 4'(5 + NUM_C);
    localparam logic [3:0] GAP_LAST  = 4'(GAP - 1);
    localparam logic [7:0] POLL_LAST = 8'(POLL_LIMIT - 1);
    localparam logic [1:0] RETRY_MAX = 2'(MAX_RETRY);

    logic [1:0]           state;
    logic [3:0]           widx;
    logic [3:0]           gcnt;
    logic [7:0]           pcnt;
    logic [1:0]           retry;
    logic                 g_poll;
    logic [17:0]          m_lat;
    logic [17:0]          n_lat;
    logic [18*NUM_C-1:0]  c_lat;
    logic [3:0]           bw_lat;
    logic [2:0]           cp_lat;

    logic                 wr_en;
    logic                 rd_en;
    logic [4:0]           c_idx;
    logic [17:0]          c_sel;
    logic [5:0]           waddr;
    logic [31:0]          wdata;
    logic                 to_poll;
    logic [1:0]           hop;
    logic                 unused_rd;

    assign wr_en     = (state == S_WR);
    assign rd_en     = (state == S_POLL);
    assign c_idx     = {1'b0, widx - W_C0};
    assign unused_rd = ^mgmt.readdata[31:1];

    always_comb begin
        c_sel = c_lat[17:0];
        for (int i = 0; i < NUM_C; i++)
            if (c_idx == 5'(i)) c_sel = c_lat[18*i +: 18];
    end

    always_comb begin
        waddr = 6'h02;
        wdata = 32'd1;
        if (widx == 4'd0) begin
            waddr = 6'h00;
        end else if (widx == 4'd1) begin
            waddr = 6'h04;
            wdata = {14'd0, m_lat};
        end else if (widx == 4'd2) begin
            waddr = 6'h03;
            wdata = {14'd0, n_lat};
        end else if (widx < W_BW) begin
            waddr = 6'h05;
            wdata = {9'd0, c_idx, c_sel};
        end else if (widx == W_BW) begin
            waddr = 6'h08;
            wdata = {28'd0, bw_lat};
        end else if (widx == W_CP) begin
            waddr = 6'h09;
            wdata = {29'd0, cp_lat};
        end
    end

    assign mgmt.write     = wr_en;
    assign mgmt.read      = rd_en;
    assign mgmt.address   = wr_en ? waddr : (rd_en ? 6'h01 : 6'h00);
    assign mgmt.writedata = wr_en ? wdata : 32'd0;

    // Where the bus goes after an accepted transfer; the gap state is
    // skipped entirely when no idle cycles are configured.
    always_comb begin
        to_poll = 1'b1;
        if (state == S_WR) to_poll = (widx == W_ST);
        else if (pcnt == POLL_LAST) to_poll = 1'b0;
    end

    assign hop = (GAP == 0) ? (to_poll ? S_POLL : S_WR) : S_GAP;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            widx   <= 4'd0;
            gcnt   <= 4'd0;
            pcnt   <= 8'd0;
            retry  <= 2'd0;
            g_poll <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            error  <= 1'b0;
            m_lat  <= '0;
            n_lat  <= '0;
            c_lat  <= '0;
            bw_lat <= '0;
            cp_lat <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: if (start) begin
                    m_lat  <= cfg_m;
                    n_lat  <= cfg_n;
                    c_lat  <= cfg_c;
                    bw_lat <= cfg_bw;
                    cp_lat <= cfg_cp;
                    error  <= 1'b0;
                    busy   <= 1'b1;
                    widx   <= 4'd0;
                    pcnt   <= 8'd0;
                    retry  <= 2'd0;
                    state  <= S_WR;
                end
                S_WR: if (!mgmt.waitrequest) begin
                    if (widx != W_ST) widx <= widx + 4'd1;
                    g_poll <= to_poll;
                    gcnt   <= 4'd0;
                    state  <= hop;
                end
                S_GAP: begin
                    if (gcnt == GAP_LAST) state <= g_poll ? S_POLL : S_WR;
                    else gcnt <= gcnt + 4'd1;
                end
                S_POLL: if (!mgmt.waitrequest) begin
                    if (mgmt.readdata[0]) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end else if (pcnt != POLL_LAST) begin
                        pcnt   <= pcnt + 8'd1;
                        g_poll <= 1'b1;
                        gcnt   <= 4'd0;
                        state  <= hop;
                    end else if (retry != RETRY_MAX) begin
                        // widx still points at START, so the rewrite reuses it
                        retry  <= retry + 2'd1;
                        pcnt   <= 8'd0;
                        g_poll <= 1'b0;
                        gcnt   <= 4'd0;
                        state  <= hop;
                    end else begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        assert (NUM_C >= 1 && NUM_C <= 8)
            else $error("NUM_C must be within 1..8");
        assert (!(wr_en && rd_en))
            else $error("mgmt read and write asserted together");
    end
endmodule

// File: tb/tb_pll_reconfig_sequencer.sv
// Directed bench for pll_reconfig_sequencer: a queue-based transaction
// model checked every cycle, plus hand-computed timing and data literals.
module tb_pll_reconfig_sequencer;
    localparam int NC = 3;
    localparam int GP = 2;
    localparam int PL = 4;
    localparam int MR = 1;

    typedef struct packed {
        logic        rd;
        logic [5:0]  a;
        logic [31:0] d;
    } op_t;

    typedef struct {
        int          cyc;
        bit          rd;
        logic [5:0]  a;
        logic [31:0] d;
    } ev_t;

    logic            clk = 1'b0;
    logic            reset;
    logic            start = 1'b0;
    logic [17:0]     cfg_m;
    logic [17:0]     cfg_n;
    logic [18*NC-1:0] cfg_c;
    logic [3:0]      cfg_bw;
    logic [2:0]      cfg_cp;
    logic            busy;
    logic            done;
    logic            error;

    pll_reconfig_sequencer_if mgmt ();

    pll_reconfig_sequencer #(
        .NUM_C(NC), .GAP(GP), .POLL_LIMIT(PL), .MAX_RETRY(MR)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .cfg_m(cfg_m), .cfg_n(cfg_n), .cfg_c(cfg_c),
        .cfg_bw(cfg_bw), .cfg_cp(cfg_cp),
        .busy(busy), .done(done), .error(error),
        .mgmt(mgmt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_done = 0;
    int done_cyc = 0;
    int m_hi = 0;
    ev_t log_q[$];

    op_t q[$];
    bit  active = 0;
    int  gap_left = 0;
    int  polls = 0;
    int  retries = 0;
    logic e_busy = 0, e_done = 0, e_err = 0, e_wr = 0, e_rd = 0;
    logic [5:0]  e_addr = 0;
    logic [31:0] e_data = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic op_t mk(input logic rd, input logic [5:0] a,
                               input logic [31:0] d);
        op_t o;
        o.rd = rd;
        o.a  = a;
        o.d  = d;
        return o;
    endfunction

    function automatic ev_t ev(input int i);
        ev_t e = '{-1, 1'b0, 6'h3f, 32'hffffffff};
        if (i < log_q.size()) e = log_q[i];
        return e;
    endfunction

    // Expected transfer list straight from the programming order.
    task automatic build();
        q.delete();
        q.push_back(mk(1'b0, 6'h00, 32'd1));
        q.push_back(mk(1'b0, 6'h04, {14'd0, cfg_m}));
        q.push_back(mk(1'b0, 6'h03, {14'd0, cfg_n}));
        for (int i = 0; i < NC; i++)
            q.push_back(mk(1'b0, 6'h05, {9'd0, 5'(i), cfg_c[18*i +: 18]}));
        q.push_back(mk(1'b0, 6'h08, {28'd0, cfg_bw}));
        q.push_back(mk(1'b0, 6'h09, {29'd0, cfg_cp}));
        q.push_back(mk(1'b0, 6'h02, 32'd1));
    endtask

    task automatic model_step();
        op_t op;
        if (reset) begin
            q.delete();
            active = 0;
            gap_left = 0;
            e_busy = 0;
            e_done = 0;
            e_err = 0;
        end else begin
            e_done = 0;
            if (!active) begin
                if (start) begin
                    build();
                    active = 1;
                    e_busy = 1;
                    e_err = 0;
                    gap_left = 0;
                    polls = 0;
                    retries = 0;
                end
            end else if (gap_left > 0) begin
                gap_left--;
            end else if (!mgmt.waitrequest) begin
                op = q[0];
                if (!op.rd) begin
                    void'(q.pop_front());
                    gap_left = GP;
                    if (op.a == 6'h02) q.push_back(mk(1'b1, 6'h01, 32'd0));
                end else if (mgmt.readdata[0]) begin
                    q.delete();
                    active = 0;
                    e_busy = 0;
                    e_done = 1;
                end else begin
                    polls++;
                    gap_left = GP;
                    if (polls == PL) begin
                        if (retries < MR) begin
                            retries++;
                            polls = 0;
                            q[0] = mk(1'b0, 6'h02, 32'd1);
                        end else begin
                            q.delete();
                            active = 0;
                            e_busy = 0;
                            e_done = 1;
                            e_err = 1;
                        end
                    end
                end
            end
        end
        if (active && gap_left == 0) begin
            e_wr   = !q[0].rd;
            e_rd   = q[0].rd;
            e_addr = q[0].a;
            e_data = q[0].d;
        end else begin
            e_wr   = 0;
            e_rd   = 0;
            e_addr = 0;
            e_data = 0;
        end
    endtask

    initial forever begin
        @(posedge clk or posedge reset);
        model_step();
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        chk("busy", busy, e_busy);
        chk("done", done, e_done);
        chk("error", error, e_err);
        chk("write", mgmt.write, e_wr);
        chk("read", mgmt.read, e_rd);
        chk("rw_excl", mgmt.read & mgmt.write, 0);
        if (e_wr || e_rd) chk("address", mgmt.address, e_addr);
        if (e_wr) chk("writedata", mgmt.writedata, e_data);
    end

    initial forever begin
        @(negedge clk);
        if ((mgmt.write || mgmt.read) && !mgmt.waitrequest)
            log_q.push_back('{cyc, mgmt.read, mgmt.address, mgmt.writedata});
        if (mgmt.write && mgmt.address == 6'h04) m_hi++;
        if (done) begin
            n_done++;
            done_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(output int t);
        start = 1'b1;
        tick();
        start = 1'b0;
        t = cyc;
    endtask

    task automatic wait_done(input int nb, input int lim, input string nm);
        int k = 0;
        while (n_done == nb && k < lim) begin
            tick();
            k++;
        end
        chk(nm, n_done != nb, 1);
    endtask

    int t0;
    int nb;
    int nw;

    initial begin
        reset = 1'b1;
        cfg_m  = 18'h02525;
        cfg_n  = 18'h20302;
        cfg_c  = {18'h10000, 18'h20302, 18'h00101};
        cfg_bw = 4'h7;
        cfg_cp = 3'h3;
        mgmt.waitrequest = 1'b0;
        mgmt.readdata    = 32'd1;
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_write", mgmt.write, 0);
        chk("rst_read", mgmt.read, 0);
        chk("rst_addr", mgmt.address, 0);
        chk("rst_wdata", mgmt.writedata, 0);
        tick();

        // basic sequence, first poll succeeds
        log_q.delete();
        nb = n_done;
        go(t0);
        wait_done(nb, 100, "basic_timeout");
        chk("basic_events", log_q.size(), 10);
        chk("w0_cyc", ev(0).cyc - t0, 0);
        chk("w1_cyc", ev(1).cyc - t0, 3);
        chk("w2_cyc", ev(2).cyc - t0, 6);
        chk("w0_addr", ev(0).a, 6'h00);
        chk("m_data", ev(1).d, 32'h00002525);
        chk("n_addr", ev(2).a, 6'h03);
        chk("c0_data", ev(3).d, 32'h00000101);
        chk("c1_data", ev(4).d, 32'h00060302);
        chk("c2_data", ev(5).d, 32'h00090000);
        chk("bw_data", ev(6).d, 32'h7);
        chk("cp_addr", ev(7).a, 6'h09);
        chk("st_addr", ev(8).a, 6'h02);
        chk("poll_addr", ev(9).a, 6'h01);
        chk("poll_cyc", ev(9).cyc - t0, 27);
        chk("done_cyc", done_cyc - t0, 28);
        repeat (2) tick();

        // waitrequest held on the M write for 5 cycles
        log_q.delete();
        m_hi = 0;
        nb = n_done;
        go(t0);
        repeat (2) tick();
        mgmt.waitrequest = 1'b1;
        repeat (6) tick();
        mgmt.waitrequest = 1'b0;
        wait_done(nb, 100, "stall_timeout");
        chk("stall_m_cycles", m_hi, 6);
        chk("stall_m_acc", ev(1).cyc - t0, 8);
        chk("stall_next", ev(2).cyc - t0, 11);
        chk("stall_done", done_cyc - t0, 33);
        repeat (2) tick();

        // status never completes: timeout, one retry, then error
        log_q.delete();
        mgmt.readdata = 32'd0;
        nb = n_done;
        go(t0);
        wait_done(nb, 200, "retry_timeout");
        nw = 0;
        foreach (log_q[i]) if (!log_q[i].rd) nw++;
        chk("retry_writes", nw, 10);
        chk("retry_reads", log_q.size() - nw, 8);
        chk("retry_st_addr", ev(13).a, 6'h02);
        chk("retry_st_cyc", ev(13).cyc - t0, 39);
        chk("retry_done", done_cyc - t0, 52);
        tick();
        chk("error_sticky", error, 1);
        tick();

        // next start clears error
        mgmt.readdata = 32'd1;
        nb = n_done;
        go(t0);
        chk("error_clr", error, 0);
        chk("busy_set", busy, 1);
        wait_done(nb, 100, "clr_timeout");
        repeat (2) tick();

        // start while busy and cfg change after acceptance
        log_q.delete();
        nb = n_done;
        go(t0);
        tick();
        start = 1'b1;
        cfg_m = 18'h1abcd;
        tick();
        start = 1'b0;
        wait_done(nb, 100, "busy_timeout");
        chk("busy_m_data", ev(1).d, 32'h00002525);
        chk("busy_events", log_q.size(), 10);
        chk("busy_done", done_cyc - t0, 28);
        cfg_m = 18'h02525;
        repeat (2) tick();

        // reset during the first C write
        nb = n_done;
        go(t0);
        repeat (9) tick();
        chk("c_wr_pre", mgmt.write && mgmt.address == 6'h05, 1);
        reset = 1'b1;
        #1;
        chk("rst_mid_wr", mgmt.write, 0);
        chk("rst_mid_busy", busy, 0);
        repeat (2) tick();
        reset = 1'b0;
        tick();
        chk("rst_no_done", n_done, nb);
        log_q.delete();
        go(t0);
        wait_done(nb, 100, "rerun_timeout");
        chk("rerun_first", ev(0).a, 6'h00);
        chk("rerun_cyc", ev(0).cyc - t0, 0);
        chk("rerun_events", log_q.size(), 10);
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
